// File: rtl/fir_stream_controller_if.sv
// Signal bundle between fir_stream_controller and its surroundings:
// sample RAM read port, FIR filter in/out, playback control and status.
interface fir_stream_controller_if #(
    parameter int N  = 16,
    parameter int AW = 11
);
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [AW-1:0]       mem_addr;
    logic                mem_rd;
    logic signed [N-1:0] mem_data;
    logic signed [N-1:0] fir_in;
    logic                fir_in_valid;
    logic signed [N-1:0] fir_out;
    logic signed [N-1:0] out_data;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic [15:0]         wrap_count;

    modport master (
        input  start, stop, loop_en, mem_data, fir_out,
        output mem_addr, mem_rd, fir_in, fir_in_valid, out_data, out_valid,
               busy, done, wrap_count
    );

    modport slave (
        output start, stop, loop_en, mem_data, fir_out,
        input  mem_addr, mem_rd, fir_in, fir_in_valid, out_data, out_valid,
               busy, done, wrap_count
    );
endinterface

// File: rtl/fir_stream_controller.sv
// Plays samples from a synchronous RAM into a fixed-latency FIR filter, one-shot or looped,
// and tracks the filter latency so every issued read yields exactly one out_valid cycle.
module fir_stream_controller #(
    parameter int N       = 16,
    parameter int DEPTH   = 1500,
    parameter int AW      = 11,
    parameter int FIR_LAT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_stream_controller_if.master bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                rd_q, rd_d;
    logic [15:0]         wrap_cnt_q, wrap_cnt_d;
    logic                done_q, done_d;

    logic                rd_p1_q;
    logic                vld_p2_q;
    logic signed [N-1:0] fir_in_p2_q;
    logic [FIR_LAT:0]    vld_sr_q;
    logic signed [N-1:0] out_data_q;

    logic                at_last;
    logic                pipe_empty;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign at_last    = (addr_q == LAST_ADDR);
    // Nothing issued, in the RAM, at the filter input, or inside the filter latency window.
    assign pipe_empty = !rd_q && !rd_p1_q && !vld_p2_q && (vld_sr_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.stop || (at_last && !bus.loop_en)) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rd_d       = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d     = '0;
                    rd_d       = 1'b1;
                    wrap_cnt_d = '0;
                end
            end
            RUN: begin
                // stop wins over the wrap and over the last one-shot read: no read, address holds
                if (!bus.stop) begin
                    if (!at_last) begin
                        addr_d = addr_q + 1'b1;
                        rd_d   = 1'b1;
                    end else if (bus.loop_en) begin
                        addr_d     = '0;
                        rd_d       = 1'b1;
                        wrap_cnt_d = sat_inc16(wrap_cnt_q);
                    end
                end
            end
            DRAIN:   done_d = pipe_empty;
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wrap_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wrap_cnt_q <= wrap_cnt_d;
            done_q     <= done_d;
        end
    end

    // p1: RAM data returns; p2: filter input; then FIR_LAT+1 stages to the registered output
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p1_q     <= 1'b0;
            vld_p2_q    <= 1'b0;
            fir_in_p2_q <= '0;
            vld_sr_q    <= '0;
            out_data_q  <= '0;
        end else begin
            rd_p1_q     <= rd_q;
            vld_p2_q    <= rd_p1_q;
            fir_in_p2_q <= rd_p1_q ? bus.mem_data : '0;
            vld_sr_q    <= {vld_sr_q[FIR_LAT-1:0], vld_p2_q};
            out_data_q  <= bus.fir_out;
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_rd       = rd_q;
    assign bus.fir_in       = fir_in_p2_q;
    assign bus.fir_in_valid = vld_p2_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = vld_sr_q[FIR_LAT];
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.wrap_count   = wrap_cnt_q;

endmodule

// File: tb/tb_fir_stream_controller.sv
// Directed bench for fir_stream_controller: DEPTH=8, FIR_LAT=4, RAM[i]=i+1, filter = 4-cycle delay line.
module tb_fir_stream_controller;

    localparam int N       = 16;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int FIR_LAT = 4;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    fir_stream_controller_if #(.N(N), .AW(AW)) bus ();

    fir_stream_controller #(
        .N(N), .DEPTH(DEPTH), .AW(AW), .FIR_LAT(FIR_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: data for a strobed address appears the next cycle.
    always_ff @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= $signed({13'd0, bus.mem_addr} + 16'd1);
    end

    // FIR model: pure delay line of FIR_LAT cycles.
    logic signed [N-1:0] dl [FIR_LAT] = '{default: '0};
    always_ff @(posedge clk) begin
        dl[0] <= bus.fir_in;
        for (int k = 1; k < FIR_LAT; k++) dl[k] <= dl[k-1];
    end
    assign bus.fir_out = dl[FIR_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tn);
        chk({tn, " mem_addr"},     32'(bus.mem_addr), 0);
        chk({tn, " mem_rd"},       32'(bus.mem_rd), 0);
        chk({tn, " fir_in"},       32'(bus.fir_in), 0);
        chk({tn, " fir_in_valid"}, 32'(bus.fir_in_valid), 0);
        chk({tn, " out_data"},     32'(bus.out_data), 0);
        chk({tn, " out_valid"},    32'(bus.out_valid), 0);
        chk({tn, " busy"},         32'(bus.busy), 0);
        chk({tn, " done"},         32'(bus.done), 0);
        chk({tn, " wrap_count"},   32'(bus.wrap_count), 0);
    endtask

    // Caller has just clocked in start (cycle 0); this checks cycles 1..20 of a one-shot pass.
    task automatic run_oneshot(input string tn, input int pulse_start_at);
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("%s addr c%0d", tn, c),   32'(bus.mem_addr), (c <= 8) ? c - 1 : 7);
            chk($sformatf("%s rd c%0d", tn, c),     32'(bus.mem_rd), 32'(c <= 8));
            chk($sformatf("%s fivld c%0d", tn, c),  32'(bus.fir_in_valid), 32'(c >= 3 && c <= 10));
            chk($sformatf("%s fin c%0d", tn, c),    32'(bus.fir_in), (c >= 3 && c <= 10) ? c - 2 : 0);
            chk($sformatf("%s ovld c%0d", tn, c),   32'(bus.out_valid), 32'(c >= 8 && c <= 15));
            chk($sformatf("%s odata c%0d", tn, c),  32'(bus.out_data), (c >= 8 && c <= 15) ? c - 7 : 0);
            chk($sformatf("%s busy c%0d", tn, c),   32'(bus.busy), 32'(c <= 16));
            chk($sformatf("%s done c%0d", tn, c),   32'(bus.done), 32'(c == 17));
            chk($sformatf("%s wrap c%0d", tn, c),   32'(bus.wrap_count), 0);
            bus.start = (c == pulse_start_at);
            bus.stop  = 1'b0;
            tick();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        repeat (3) tick();
        chk_all_zero("RST");
        reset = 1'b0;
        repeat (4) tick();
        chk("IDLE busy", 32'(bus.busy), 0);

        // T1: one-shot pass
        bus.start = 1'b1;
        tick();
        run_oneshot("T1", 0);

        // T2: looped playback, stop clocked in during the 20th read
        bus.loop_en = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            chk($sformatf("T2 rd c%0d", c),    32'(bus.mem_rd), 32'(c <= 20));
            chk($sformatf("T2 addr c%0d", c),  32'(bus.mem_addr), (c <= 20) ? (c - 1) % 8 : 3);
            chk($sformatf("T2 wrap c%0d", c),  32'(bus.wrap_count), (c <= 20) ? (c - 1) / 8 : 2);
            chk($sformatf("T2 ovld c%0d", c),  32'(bus.out_valid), 32'(c >= 8 && c <= 27));
            chk($sformatf("T2 odata c%0d", c), 32'(bus.out_data), (c >= 8 && c <= 27) ? ((c - 8) % 8) + 1 : 0);
            chk($sformatf("T2 done c%0d", c),  32'(bus.done), 32'(c == 29));
            bus.stop = (c == 20);
            tick();
        end
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;

        // T3: stop clocked in at the edge that would have issued the 3rd read
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("T3 rd c%0d", c),    32'(bus.mem_rd), 32'(c <= 2));
            chk($sformatf("T3 addr c%0d", c),  32'(bus.mem_addr), (c <= 2) ? c - 1 : 1);
            chk($sformatf("T3 fivld c%0d", c), 32'(bus.fir_in_valid), 32'(c == 3 || c == 4));
            chk($sformatf("T3 fin c%0d", c),   32'(bus.fir_in), (c == 3 || c == 4) ? c - 2 : 0);
            chk($sformatf("T3 ovld c%0d", c),  32'(bus.out_valid), 32'(c == 8 || c == 9));
            chk($sformatf("T3 odata c%0d", c), 32'(bus.out_data), (c == 8 || c == 9) ? c - 7 : 0);
            chk($sformatf("T3 busy c%0d", c),  32'(bus.busy), 32'(c <= 10));
            chk($sformatf("T3 done c%0d", c),  32'(bus.done), 32'(c == 11));
            bus.stop = (c == 2);
            tick();
        end
        bus.stop = 1'b0;

        // T4: stop alone in IDLE does nothing; start+stop together starts; start in RUN ignored
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("T4 idle-stop busy", 32'(bus.busy), 0);
        chk("T4 idle-stop rd",   32'(bus.mem_rd), 0);
        tick();
        chk("T4 idle-stop busy2", 32'(bus.busy), 0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        run_oneshot("T4", 3);

        // T5: reset for one cycle while draining
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("T5 in drain busy", 32'(bus.busy), 1);
        chk("T5 in drain rd",   32'(bus.mem_rd), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("T5 post-reset");
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("T5 no-done c%0d", c), 32'(bus.done), 0);
            chk($sformatf("T5 no-ovld c%0d", c), 32'(bus.out_valid), 0);
            chk($sformatf("T5 no-busy c%0d", c), 32'(bus.busy), 0);
        end
        bus.start = 1'b1;
        tick();
        run_oneshot("T5 replay", 0);

        // T6: wrap counter saturation
        bus.loop_en = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        force dut.wrap_cnt_q = 16'hFFFE;
        #1;
        release dut.wrap_cnt_q;
        for (int c = 1; c <= 25; c++) begin
            chk($sformatf("T6 wrap c%0d", c), 32'(bus.wrap_count), (c <= 8) ? 32'hFFFE : 32'hFFFF);
            bus.stop = (c == 25);
            tick();
        end
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        for (int c = 26; c <= 35; c++) begin
            chk($sformatf("T6 done c%0d", c),  32'(bus.done), 32'(c == 34));
            chk($sformatf("T6 wrap2 c%0d", c), 32'(bus.wrap_count), 32'hFFFF);
            tick();
        end
        chk("T6 final busy", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
